// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller and the renderer.
// Optional feature macro: GAME_PAUSE_EN (adds the PAUSED state).
package game_pkg;

    localparam int LIVES_W = 4;

    typedef enum logic [2:0] {
        ST_START          = 3'd0,
        ST_WAIT_REL_START = 3'd1,
        ST_PLAYING        = 3'd2,
        ST_RESPAWN        = 3'd3,
        ST_GAMEOVER       = 3'd4,
`ifdef GAME_PAUSE_EN
        ST_WAIT_REL_OVER  = 3'd5,
        ST_PAUSED         = 3'd6
`else
        ST_WAIT_REL_OVER  = 3'd5
`endif
    } game_state_t;

endpackage

// File: rtl/game_flow_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes its next value so
// callers can register quantities derived from the count in lock-step.
module sat_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    // Next value: clear wins, increment stops at all-ones.
    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (inc && (count != {WIDTH{1'b1}}))
            count_next = count + WIDTH'(1);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count_next;
    end

endmodule

// File: rtl/game_flow_fsm.sv
// Game-flow controller for the endless runner: lives, timed respawn,
// saturating score, difficulty level and session high score.
// Optional feature macro: GAME_PAUSE_EN (pause_in edge toggles PLAYING<->PAUSED).
module game_flow_fsm
    import game_pkg::*;
#(
    parameter int SCORE_W       = 12,
    parameter int LIVES         = 3,
    parameter int LEVEL_W       = 3,
    parameter int LEVEL_SHIFT   = 6,
    parameter int RESPAWN_TICKS = 30
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               pulse,
    input  logic               died,
    input  logic               jump,
    input  logic               pause_in,
    output logic               playing,
    output logic               respawning,
    output logic               game_over,
    output logic               reset_game,
    output logic [SCORE_W-1:0] time_alive,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic [LIVES_W-1:0] lives_left,
    output logic [LEVEL_W-1:0] level
);

    localparam int RC_W = $clog2(RESPAWN_TICKS + 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

    game_state_t        state_q, state_d;
    logic [LIVES_W-1:0] lives_d;
    logic [RC_W-1:0]    rcnt_q, rcnt_d;
    logic               entry_q, entry_d;
    logic               ta_inc, ta_clr;
    logic [SCORE_W-1:0] ta_next;
    logic [SCORE_W-1:0] lvl_raw;
    logic [LEVEL_W-1:0] level_d;

`ifdef GAME_PAUSE_EN
    logic pause_q;
    logic pause_edge;
    assign pause_edge = pause_in & ~pause_q;

    // Previous pause level, tracked in every state so edges are clean.
    always_ff @(posedge clk_in) begin
        if (rst_in) pause_q <= 1'b0;
        else        pause_q <= pause_in;
    end
`else
    logic unused_pause;
    assign unused_pause = pause_in;
`endif

    sat_counter #(.WIDTH(SCORE_W)) u_score (
        .clk        (clk_in),
        .rst        (rst_in),
        .inc        (ta_inc),
        .clr        (ta_clr),
        .count      (time_alive),
        .count_next (ta_next)
    );

    // Next-state, lives, respawn timer and score control.
    always_comb begin
        state_d = state_q;
        lives_d = lives_left;
        rcnt_d  = rcnt_q;
        entry_d = 1'b0;
        ta_inc  = 1'b0;
        ta_clr  = 1'b0;
        case (state_q)
            ST_START: begin
                if (jump) begin
                    state_d = ST_WAIT_REL_START;
                    ta_clr  = 1'b1;
                    lives_d = LIVES_W'(LIVES);
                end
            end
            ST_WAIT_REL_START: begin
                if (!jump) state_d = ST_PLAYING;
            end
            ST_PLAYING: begin
                // Death outranks both a pause edge and a score tick.
                if (died) begin
                    if (lives_left > LIVES_W'(1)) begin
                        state_d = ST_RESPAWN;
                        lives_d = lives_left - LIVES_W'(1);
                        rcnt_d  = RC_W'(RESPAWN_TICKS);
                    end else begin
                        state_d = ST_GAMEOVER;
                        lives_d = '0;
                        entry_d = 1'b1;
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (pause_edge) begin
                    state_d = ST_PAUSED;
                end
`endif
                else if (pulse) begin
                    ta_inc = 1'b1;
                end
            end
            ST_RESPAWN: begin
                if (pulse) begin
                    if (rcnt_q == RC_W'(1)) state_d = ST_PLAYING;
                    else                    rcnt_d  = rcnt_q - RC_W'(1);
                end
            end
            ST_GAMEOVER: begin
                if (jump) state_d = ST_WAIT_REL_OVER;
            end
            ST_WAIT_REL_OVER: begin
                if (!jump) state_d = ST_START;
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSED: begin
                if (pause_edge) state_d = ST_PLAYING;
            end
`endif
            default: state_d = ST_START;
        endcase
    end

    // Level tracks the score value being registered this cycle.
    always_comb begin
        lvl_raw = ta_next >> LEVEL_SHIFT;
        if (lvl_raw > SCORE_W'(LEVEL_MAX)) level_d = LEVEL_MAX;
        else                               level_d = lvl_raw[LEVEL_W-1:0];
    end

    // State, lives, timer and level registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_START;
            lives_left <= LIVES_W'(LIVES);
            rcnt_q     <= '0;
            entry_q    <= 1'b0;
            level      <= '0;
        end else begin
            state_q    <= state_d;
            lives_left <= lives_d;
            rcnt_q     <= rcnt_d;
            entry_q    <= entry_d;
            level      <= level_d;
        end
    end

    // High score is compared on the first GAMEOVER cycle only.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            high_score <= '0;
            new_high   <= 1'b0;
        end else begin
            new_high <= 1'b0;
            if (entry_q && (time_alive > high_score)) begin
                high_score <= time_alive;
                new_high   <= 1'b1;
            end
        end
    end

    // State-decoded outputs, registered one cycle behind the state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            playing    <= 1'b0;
            respawning <= 1'b0;
            game_over  <= 1'b0;
            reset_game <= 1'b1;
        end else begin
            playing    <= (state_q == ST_PLAYING);
            respawning <= (state_q == ST_RESPAWN);
            game_over  <= (state_q == ST_GAMEOVER) || (state_q == ST_WAIT_REL_OVER);
            reset_game <= (state_q == ST_START);
        end
    end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Scoreboard bench for game_flow_fsm: directed scenarios then random play,
// checked against a behavioural game model.
module tb_game_flow_fsm;

    localparam int SW = 5;
    localparam int LV = 3;
    localparam int LW = 2;
    localparam int LS = 2;
    localparam int RT = 5;
    localparam int SMAX = (1 << SW) - 1;
    localparam int LMAX = (1 << LW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1, pulse = 1'b0, died = 1'b0, jump = 1'b0, pause_in = 1'b0;
    logic playing, respawning, game_over, reset_game, new_high;
    logic [SW-1:0] time_alive, high_score;
    logic [3:0]    lives_left;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    game_flow_fsm #(.SCORE_W(SW), .LIVES(LV), .LEVEL_W(LW), .LEVEL_SHIFT(LS),
                    .RESPAWN_TICKS(RT)) dut (
        .clk_in(clk), .rst_in(rst), .pulse(pulse), .died(died), .jump(jump),
        .pause_in(pause_in), .playing(playing), .respawning(respawning),
        .game_over(game_over), .reset_game(reset_game), .time_alive(time_alive),
        .high_score(high_score), .new_high(new_high), .lives_left(lives_left),
        .level(level)
    );

    typedef struct {
        int play, resp, over, rg, ta, hs, nh, lives, lvl;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Game model: phases of play, in the words of the game.
    localparam int G_TITLE = 0, G_ARMED = 1, G_RUN = 2, G_BLINK = 3,
                   G_DEAD = 4, G_DEAD_REL = 5, G_HOLD = 6;
    int  g_phase = G_TITLE;
    int  g_score = 0, g_lives = LV, g_blink = 0, g_best = 0;
    bit  g_just_died = 0, g_prev_pause = 0, g_nh = 0;
    int  o_play = 0, o_resp = 0, o_over = 0, o_rg = 1;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model(bit r, bit p, bit d, bit j, bit pa);
        bit pedge;
        exp_t e;
        if (r) begin
            g_phase = G_TITLE; g_score = 0; g_lives = LV; g_best = 0; g_nh = 0;
            g_just_died = 0; g_prev_pause = 0; g_blink = 0;
            o_play = 0; o_resp = 0; o_over = 0; o_rg = 1;
        end else begin
            // Phase flags appear one cycle after the phase itself.
            o_play = int'(g_phase == G_RUN);
            o_resp = int'(g_phase == G_BLINK);
            o_over = int'(g_phase == G_DEAD || g_phase == G_DEAD_REL);
            o_rg   = int'(g_phase == G_TITLE);
            g_nh = 0;
            if (g_just_died && g_score > g_best) begin
                g_best = g_score;
                g_nh = 1;
            end
            g_just_died = 0;
`ifdef GAME_PAUSE_EN
            pedge = pa && !g_prev_pause;
`else
            pedge = 0;
`endif
            g_prev_pause = pa;
            case (g_phase)
                G_TITLE: if (j) begin g_phase = G_ARMED; g_score = 0; g_lives = LV; end
                G_ARMED: if (!j) g_phase = G_RUN;
                G_RUN: begin
                    if (d) begin
                        g_lives = g_lives - 1;
                        if (g_lives > 0) begin g_phase = G_BLINK; g_blink = RT; end
                        else begin g_phase = G_DEAD; g_just_died = 1; end
                    end else if (pedge) g_phase = G_HOLD;
                    else if (p && g_score < SMAX) g_score++;
                end
                G_BLINK: if (p) begin
                    g_blink--;
                    if (g_blink == 0) g_phase = G_RUN;
                end
                G_DEAD: if (j) g_phase = G_DEAD_REL;
                G_DEAD_REL: if (!j) g_phase = G_TITLE;
                G_HOLD: if (pedge) g_phase = G_RUN;
                default: g_phase = G_TITLE;
            endcase
        end
        e.play = o_play; e.resp = o_resp; e.over = o_over; e.rg = o_rg;
        e.ta = g_score; e.hs = g_best; e.nh = g_nh; e.lives = g_lives;
        e.lvl = ((g_score >> LS) > LMAX) ? LMAX : (g_score >> LS);
        sb.push_back(e);
    endtask

    task automatic step(bit r, bit p, bit d, bit j, bit pa);
        @(negedge clk);
        rst = r; pulse = p; died = d; jump = j; pause_in = pa;
        model(r, p, d, j, pa);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic pulses(int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic start_game();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        idle(2);
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("playing",    int'(playing),    e.play);
                chk("respawning", int'(respawning), e.resp);
                chk("game_over",  int'(game_over),  e.over);
                chk("reset_game", int'(reset_game), e.rg);
                chk("time_alive", int'(time_alive), e.ta);
                chk("high_score", int'(high_score), e.hs);
                chk("new_high",   int'(new_high),   e.nh);
                chk("lives_left", int'(lives_left), e.lives);
                chk("level",      int'(level),      e.lvl);
            end
        end
    end

    // Stimulus.
    initial begin
        int wait_cnt;
        bit jl, pl;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(2);
        // First game: score 5, one death, held died through respawn.
        start_game();
        pulses(5);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < RT - 1; i++) begin
            step(0, 1, 1, 0, 0);
            step(0, 0, 1, 0, 0);
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(2);
        // Death and tick together: no increment.
        step(0, 1, 1, 0, 0);
        pulses(RT);
        idle(2);
        // Saturate the score, then lose the last life.
        pulses(SMAX + 5);
        step(0, 0, 1, 0, 0);
        idle(4);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        idle(3);
        // Second game with a lower score.
        start_game();
        pulses(3);
        for (int k = 0; k < LV; k++) begin
            step(0, 0, 1, 0, 0);
            pulses(RT);
            idle(1);
        end
        idle(4);
        step(0, 0, 0, 1, 0);
        idle(3);
`ifdef GAME_PAUSE_EN
        // Pause, ticks and deaths ignored, resume.
        start_game();
        pulses(2);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        pulses(2);
        step(0, 0, 1, 0, 1);
        idle(3);
`endif
        // Reset in the middle of play.
        step(0, 0, 0, 1, 0);
        idle(1);
        start_game();
        pulses(6);
        step(1, 0, 0, 0, 0);
        idle(3);
        // Random play.
        jl = 0; pl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 15) jl = ~jl;
            if ($urandom_range(0, 99) < 4)  pl = ~pl;
            step(($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
                 jl, pl);
        end
        idle(1);
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
